// File: rtl/dffram_mbist_pkg.sv
// Shared types and March C- element table for the DFFRAM memory BIST.
// Optional diagnostics are enabled with MBIST_DIAG_EN (see dffram_mbist.sv).
package dffram_mbist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [2:0] ELEM_LAST = 3'd5;

    typedef struct packed {
        logic       up;      // ascending address order
        logic [1:0] ops;     // operations per address (1 or 2)
        logic       rd;      // element starts with a read
        logic       wr;      // element contains a write
        logic       rd_val;  // expected background on read
        logic       wr_val;  // background written
    } elem_cfg_t;

    function automatic elem_cfg_t elem_cfg(input logic [2:0] elem);
        elem_cfg_t cfg;
        case (elem)
            3'd0:    cfg = '{up: 1'b1, ops: 2'd1, rd: 1'b0, wr: 1'b1, rd_val: 1'b0, wr_val: 1'b0};
            3'd1:    cfg = '{up: 1'b1, ops: 2'd2, rd: 1'b1, wr: 1'b1, rd_val: 1'b0, wr_val: 1'b1};
            3'd2:    cfg = '{up: 1'b1, ops: 2'd2, rd: 1'b1, wr: 1'b1, rd_val: 1'b1, wr_val: 1'b0};
            3'd3:    cfg = '{up: 1'b0, ops: 2'd2, rd: 1'b1, wr: 1'b1, rd_val: 1'b0, wr_val: 1'b1};
            3'd4:    cfg = '{up: 1'b0, ops: 2'd2, rd: 1'b1, wr: 1'b1, rd_val: 1'b1, wr_val: 1'b0};
            3'd5:    cfg = '{up: 1'b1, ops: 2'd1, rd: 1'b1, wr: 1'b0, rd_val: 1'b0, wr_val: 1'b0};
            default: cfg = '{up: 1'b1, ops: 2'd1, rd: 1'b0, wr: 1'b1, rd_val: 1'b0, wr_val: 1'b0};
        endcase
        return cfg;
    endfunction

    function automatic logic elem_up(input logic [2:0] elem);
        elem_cfg_t cfg;
        cfg = elem_cfg(elem);
        return cfg.up;
    endfunction

endpackage

// File: rtl/dffram_mbist_cmp.sv
// Read-data compare pipeline: RD_LAT-deep expected-value shift register and sticky fail bit.
// With MBIST_DIAG_EN it also captures the first mismatch and counts mismatching reads.
module dffram_mbist_cmp
    import dffram_mbist_pkg::*;
#(
    parameter int AW     = 7,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic          clr_i,
    input  logic          push_vld_i,
    input  logic [DW-1:0] push_exp_i,
`ifdef MBIST_DIAG_EN
    input  logic [AW-1:0] push_addr_i,
    input  logic [2:0]    push_elem_i,
    output logic [AW-1:0] fail_addr_o,
    output logic [2:0]    fail_elem_o,
    output logic [DW-1:0] fail_syn_o,
    output logic [7:0]    fail_cnt_o,
`endif
    input  logic [DW-1:0] rdata_i,
    output logic          fail_o
);

    logic          vld_q [RD_LAT];
    logic [DW-1:0] exp_q [RD_LAT];
    logic          fail_q;
    logic          mism_s;

    assign mism_s = vld_q[RD_LAT-1] && (rdata_i != exp_q[RD_LAT-1]);
    assign fail_o = fail_q;

    // Expected-value pipeline aligned to the RAM read latency
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            for (int i = 0; i < RD_LAT; i++) begin
                vld_q[i] <= 1'b0;
                exp_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= push_vld_i;
            exp_q[0] <= push_exp_i;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                exp_q[i] <= exp_q[i-1];
            end
        end
    end

    // Sticky fail flag, cleared when a new run is accepted
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            fail_q <= 1'b0;
        end else if (clr_i) begin
            fail_q <= 1'b0;
        end else if (mism_s) begin
            fail_q <= 1'b1;
        end else begin
            fail_q <= fail_q;
        end
    end

`ifdef MBIST_DIAG_EN
    logic [AW-1:0] addr_q [RD_LAT];
    logic [2:0]    elem_q [RD_LAT];
    logic [AW-1:0] fail_addr_q;
    logic [2:0]    fail_elem_q;
    logic [DW-1:0] fail_syn_q;
    logic [7:0]    fail_cnt_q;

    assign fail_addr_o = fail_addr_q;
    assign fail_elem_o = fail_elem_q;
    assign fail_syn_o  = fail_syn_q;
    assign fail_cnt_o  = fail_cnt_q;

    // Address/element tags travelling alongside the expected value
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            for (int i = 0; i < RD_LAT; i++) begin
                addr_q[i] <= '0;
                elem_q[i] <= 3'd0;
            end
        end else begin
            addr_q[0] <= push_addr_i;
            elem_q[0] <= push_elem_i;
            for (int i = 1; i < RD_LAT; i++) begin
                addr_q[i] <= addr_q[i-1];
                elem_q[i] <= elem_q[i-1];
            end
        end
    end

    // First-mismatch capture plus saturating mismatch counter
    always_ff @(posedge CLK) begin
        if (!RSTn || clr_i) begin
            fail_addr_q <= '0;
            fail_elem_q <= 3'd0;
            fail_syn_q  <= '0;
            fail_cnt_q  <= 8'd0;
        end else if (mism_s) begin
            if (!fail_q) begin
                fail_addr_q <= addr_q[RD_LAT-1];
                fail_elem_q <= elem_q[RD_LAT-1];
                fail_syn_q  <= rdata_i ^ exp_q[RD_LAT-1];
            end
            if (fail_cnt_q != 8'hFF) begin
                fail_cnt_q <= fail_cnt_q + 8'd1;
            end
        end
    end
`endif

endmodule

// File: rtl/dffram_mbist.sv
// March C- BIST initiator for DFFRAM single-port macros; muxes the RAM port between system and BIST.
// Define MBIST_DIAG_EN to add first-fail address/element/syndrome and a mismatch count.
module dffram_mbist
    import dffram_mbist_pkg::*;
#(
    parameter int AW     = 7,
    parameter int WSIZE  = 4,
    parameter int RD_LAT = 1
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
`ifdef MBIST_DIAG_EN
    output logic [AW-1:0]        fail_addr,
    output logic [2:0]           fail_elem,
    output logic [8*WSIZE-1:0]   fail_syn,
    output logic [7:0]           fail_cnt,
`endif
    input  logic [WSIZE-1:0]     sys_WE0,
    input  logic                 sys_EN0,
    input  logic [AW-1:0]        sys_A0,
    input  logic [8*WSIZE-1:0]   sys_Di0,
    output logic [8*WSIZE-1:0]   sys_Do0,
    output logic [WSIZE-1:0]     WE0,
    output logic                 EN0,
    output logic [AW-1:0]        A0,
    output logic [8*WSIZE-1:0]   Di0,
    input  logic [8*WSIZE-1:0]   Do0
);

    localparam int DW  = 8 * WSIZE;
    localparam int DCW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(RD_LAT - 1);
    localparam logic [AW-1:0]  ADDR_ONE   = AW'(1);
    localparam logic [AW-1:0]  ADDR_TOP   = '1;

    state_t         state_q, state_d;
    logic [2:0]     elem_q, elem_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic           phase_q, phase_d;
    logic [DCW-1:0] drain_q, drain_d;
    logic           done_q, done_d;
    logic           pass_q, pass_d;

    elem_cfg_t cfg_s;
    logic      is_rd_s, is_wr_s, last_op_s, addr_end_s, start_acc_s, fail_s;

    assign cfg_s       = elem_cfg(elem_q);
    assign is_rd_s     = cfg_s.rd && !phase_q;
    assign is_wr_s     = cfg_s.wr && (cfg_s.rd ? phase_q : 1'b1);
    assign last_op_s   = (cfg_s.ops == 2'd2) ? phase_q : 1'b1;
    assign addr_end_s  = cfg_s.up ? (addr_q == ADDR_TOP) : (addr_q == '0);
    assign start_acc_s = start && ((state_q == IDLE) || (state_q == DONE));
    assign busy        = (state_q == RUN) || (state_q == DRAIN);
    assign done        = done_q;
    assign pass        = pass_q;
    assign sys_Do0     = Do0;

    // State and counter registers
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q <= IDLE;
            elem_q  <= 3'd0;
            addr_q  <= '0;
            phase_q <= 1'b0;
            drain_q <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            elem_q  <= elem_d;
            addr_q  <= addr_d;
            phase_q <= phase_d;
            drain_q <= drain_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    // Next-state: walk elements/addresses, then drain the compare pipe
    always_comb begin
        state_d = state_q;
        elem_d  = elem_q;
        addr_d  = addr_q;
        phase_d = phase_q;
        drain_d = drain_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    elem_d  = 3'd0;
                    addr_d  = '0;
                    phase_d = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            RUN: begin
                if (!last_op_s) begin
                    phase_d = 1'b1;
                end else if (!addr_end_s) begin
                    phase_d = 1'b0;
                    addr_d  = cfg_s.up ? (addr_q + ADDR_ONE) : (addr_q - ADDR_ONE);
                end else if (elem_q == ELEM_LAST) begin
                    phase_d = 1'b0;
                    state_d = DRAIN;
                    drain_d = '0;
                end else begin
                    phase_d = 1'b0;
                    elem_d  = elem_q + 3'd1;
                    addr_d  = elem_up(elem_q + 3'd1) ? '0 : ADDR_TOP;
                end
            end
            DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = DONE;
                end else begin
                    drain_d = drain_q + DCW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // done/pass trail entry into DONE by one cycle so the last compare is included
        done_d = (state_q == DONE) && !start;
        pass_d = done_d && !fail_s;
    end

    // RAM port mux: BIST owns the port while busy
    always_comb begin
        if (busy) begin
            WE0 = is_wr_s && (state_q == RUN) ? {WSIZE{1'b1}} : {WSIZE{1'b0}};
            EN0 = (state_q == RUN);
            A0  = addr_q;
            Di0 = {DW{cfg_s.wr_val}};
        end else begin
            WE0 = sys_WE0;
            EN0 = sys_EN0;
            A0  = sys_A0;
            Di0 = sys_Di0;
        end
    end

`ifdef MBIST_DIAG_EN
    dffram_mbist_cmp #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) u_cmp (
        .CLK         (CLK),
        .RSTn        (RSTn),
        .clr_i       (start_acc_s),
        .push_vld_i  ((state_q == RUN) && is_rd_s),
        .push_exp_i  ({DW{cfg_s.rd_val}}),
        .push_addr_i (addr_q),
        .push_elem_i (elem_q),
        .fail_addr_o (fail_addr),
        .fail_elem_o (fail_elem),
        .fail_syn_o  (fail_syn),
        .fail_cnt_o  (fail_cnt),
        .rdata_i     (Do0),
        .fail_o      (fail_s)
    );
`else
    dffram_mbist_cmp #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) u_cmp (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .clr_i      (start_acc_s),
        .push_vld_i ((state_q == RUN) && is_rd_s),
        .push_exp_i ({DW{cfg_s.rd_val}}),
        .rdata_i    (Do0),
        .fail_o     (fail_s)
    );
`endif

endmodule

// File: tb/tb_dffram_mbist.sv
// Directed bench for dffram_mbist with a behavioural DFFRAM (AW=7, WSIZE=4, RD_LAT=1) and fault injection.
// Diagnostic checks are compiled in when MBIST_DIAG_EN is defined.
module tb_dffram_mbist;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, pass;
    logic [3:0]  sys_WE0 = 4'h0;
    logic        sys_EN0 = 1'b0;
    logic [6:0]  sys_A0 = 7'h00;
    logic [31:0] sys_Di0 = 32'h0;
    logic [31:0] sys_Do0;
    logic [3:0]  WE0;
    logic        EN0;
    logic [6:0]  A0;
    logic [31:0] Di0;
    logic [31:0] Do0 = 32'h0;
`ifdef MBIST_DIAG_EN
    logic [6:0]  fail_addr;
    logic [2:0]  fail_elem;
    logic [31:0] fail_syn;
    logic [7:0]  fail_cnt;
`endif

    logic [31:0] mem [128];
    int          fault_mode = 0;
    int          n_vec = 0;
    int          n_fail = 0;

    always #5 CLK = ~CLK;

    dffram_mbist #(.AW(7), .WSIZE(4), .RD_LAT(1)) dut (
        .CLK(CLK), .RSTn(RSTn), .start(start), .busy(busy), .done(done), .pass(pass),
`ifdef MBIST_DIAG_EN
        .fail_addr(fail_addr), .fail_elem(fail_elem), .fail_syn(fail_syn), .fail_cnt(fail_cnt),
`endif
        .sys_WE0(sys_WE0), .sys_EN0(sys_EN0), .sys_A0(sys_A0), .sys_Di0(sys_Di0), .sys_Do0(sys_Do0),
        .WE0(WE0), .EN0(EN0), .A0(A0), .Di0(Di0), .Do0(Do0)
    );

    function automatic logic [31:0] rd_fault(input logic [31:0] w, input logic [6:0] a);
        logic [31:0] r;
        r = w;
        if (fault_mode == 1 && a == 7'h2A) r[5] = 1'b0;
        return r;
    endfunction

    // Behavioural DFFRAM: read-before-write, one cycle latency, optional faults
    always @(posedge CLK) begin
        if (EN0) begin
            Do0 <= rd_fault(mem[A0], A0);
            for (int b = 0; b < 4; b++) begin
                if (WE0[b]) begin
                    mem[A0][8*b +: 8] <= Di0[8*b +: 8];
                    if (fault_mode == 2 && A0 == 7'h10) mem[7'h11][8*b +: 8] <= Di0[8*b +: 8];
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Start a run and count cycles until done; optionally keep start high for 600 cycles
    task automatic do_run(input bit hold, input bit chk_port, output int cyc, output int bc,
                          output logic done0);
        @(negedge CLK) start = 1'b1;
        @(posedge CLK); #1;
        done0 = done;
        if (!hold) start = 1'b0;
        cyc = 0;
        bc = busy ? 1 : 0;
        while (!done && cyc < 3000) begin
            @(posedge CLK); #1;
            cyc++;
            if (busy) bc++;
            if (hold && cyc == 600) begin
                check("hold_busy", {63'd0, busy}, 64'd1);
                start = 1'b0;
            end
            if (chk_port && cyc == 5) begin
                check("bist_owns_port", {WE0, EN0, A0, Di0}, {4'hF, 1'b1, 7'h05, 32'h0});
            end
        end
    endtask

    typedef struct {
        logic [3:0]  we;
        logic        en;
        logic [6:0]  a;
        logic [31:0] di;
        logic        chk;
        logic [31:0] exp_do;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int cyc, bc, nz;
        logic d0;
        vecs[0] = '{4'b0011, 1'b1, 7'h05, 32'hDEADBEEF, 1'b0, 32'h0};
        vecs[1] = '{4'b0000, 1'b1, 7'h05, 32'h0,        1'b1, 32'h0000BEEF};
        vecs[2] = '{4'b1100, 1'b1, 7'h05, 32'h12345678, 1'b0, 32'h0};
        vecs[3] = '{4'b0000, 1'b1, 7'h05, 32'h0,        1'b1, 32'h1234BEEF};
        vecs[4] = '{4'b1111, 1'b1, 7'h7F, 32'hCAFEF00D, 1'b0, 32'h0};
        vecs[5] = '{4'b0000, 1'b1, 7'h7F, 32'h0,        1'b1, 32'hCAFEF00D};
        vecs[6] = '{4'b0000, 1'b0, 7'h05, 32'h0,        1'b1, 32'hCAFEF00D};
        vecs[7] = '{4'b0000, 1'b1, 7'h00, 32'h0,        1'b1, 32'h00000000};
        for (int i = 0; i < 128; i++) mem[i] = 32'hA5A5A5A5;

        // Reset values and passthrough while in reset
        repeat (3) @(posedge CLK);
        #1;
        check("rst_flags", {61'd0, busy, done, pass}, 64'd0);
        sys_EN0 = 1'b1;
        #1 check("rst_passthru", {63'd0, EN0}, 64'd1);
        sys_EN0 = 1'b0;
`ifdef MBIST_DIAG_EN
        check("rst_diag", {fail_cnt, fail_elem, fail_addr, fail_syn}, 64'd0);
`endif
        @(negedge CLK) RSTn = 1'b1;

        // Test 1: fault-free run, timing and final contents
        do_run(1'b0, 1'b1, cyc, bc, d0);
        check("t1_cycles", cyc, 1282);
        check("t1_busy_cycles", bc, 1281);
        check("t1_pass", {63'd0, pass}, 64'd1);
        nz = 0;
        for (int i = 0; i < 128; i++) if (mem[i] != 32'h0) nz++;
        check("t1_mem_zero", nz, 0);

        // Test 5: idle passthrough vectors
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            sys_WE0 = vecs[i].we; sys_EN0 = vecs[i].en; sys_A0 = vecs[i].a; sys_Di0 = vecs[i].di;
            #1 check("pt_port", {WE0, EN0, A0, Di0}, {vecs[i].we, vecs[i].en, vecs[i].a, vecs[i].di});
            @(posedge CLK); #1;
            if (vecs[i].chk) check("pt_rdata", sys_Do0, vecs[i].exp_do);
        end
        @(negedge CLK) begin sys_EN0 = 1'b0; sys_WE0 = 4'h0; end

        // Test 4: reset in the middle of a run
        @(negedge CLK) start = 1'b1;
        @(posedge CLK); #1 start = 1'b0;
        repeat (299) @(posedge CLK);
        @(negedge CLK) begin RSTn = 1'b0; sys_EN0 = 1'b1; end
        @(posedge CLK); #1;
        check("t4_rst_flags", {62'd0, busy, done}, 64'd0);
        check("t4_en_hi", {63'd0, EN0}, 64'd1);
        sys_EN0 = 1'b0;
        #1 check("t4_en_lo", {63'd0, EN0}, 64'd0);
        @(negedge CLK) RSTn = 1'b1;
        do_run(1'b0, 1'b0, cyc, bc, d0);
        check("t4_cycles", cyc, 1282);
        check("t4_pass", {63'd0, pass}, 64'd1);

        // Test 6: start held through a run, then restart from DONE
        do_run(1'b1, 1'b0, cyc, bc, d0);
        check("t6_cycles", cyc, 1282);
        check("t6_pass", {63'd0, pass}, 64'd1);
        do_run(1'b0, 1'b0, cyc, bc, d0);
        check("t6_done_clr", {63'd0, d0}, 64'd0);
        check("t6_cycles2", cyc, 1282);
        check("t6_pass2", {63'd0, pass}, 64'd1);

        // Test 2: stuck-at-0 on bit 5 of 0x2A
        fault_mode = 1;
        do_run(1'b0, 1'b0, cyc, bc, d0);
        check("t2_cycles", cyc, 1282);
        check("t2_pass", {63'd0, pass}, 64'd0);
`ifdef MBIST_DIAG_EN
        check("t2_addr", fail_addr, 7'h2A);
        check("t2_elem", fail_elem, 3'd2);
        check("t2_syn", fail_syn, 32'h00000020);
        check("t2_cnt", fail_cnt, 8'd2);
`endif

        // Test 3: write to 0x10 also lands in 0x11
        fault_mode = 2;
        do_run(1'b0, 1'b0, cyc, bc, d0);
        check("t3_pass", {63'd0, pass}, 64'd0);
`ifdef MBIST_DIAG_EN
        check("t3_addr", fail_addr, 7'h11);
        check("t3_elem", fail_elem, 3'd1);
`endif

        // Fault removed: a new run clears the previous failure
        fault_mode = 0;
        do_run(1'b0, 1'b0, cyc, bc, d0);
        check("clean_pass", {63'd0, pass}, 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
